// File: rtl/pwm_gen.sv
// pwm_gen: multi-channel PWM with shadowed period/duty updates and a period-count watchdog
module pwm_gen #(
  parameter int NUM_CH        = 4,
  parameter int CNT_W         = 16,
  parameter int WDOG_PERIODS  = 50,
  parameter int FAILSAFE_DUTY = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    tick_i,
  input  logic                    enable_i,
  input  logic                    upd_valid_i,
  output logic                    upd_ready_o,
  input  logic [CNT_W-1:0]        period_i,
  input  logic [NUM_CH*CNT_W-1:0] duty_i,
  output logic [NUM_CH-1:0]       pwm_o,
  output logic                    period_start_o,
  output logic                    failsafe_o
);
  localparam int WD_W = (WDOG_PERIODS > 0) ? $clog2(WDOG_PERIODS + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG_PERIODS);
  localparam logic [CNT_W-1:0] FS_DUTY = CNT_W'(FAILSAFE_DUTY);
  typedef enum logic {IDLE, RUN} state_t;
  state_t                    state_q, state_d;
  logic                      tick_q;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      pend_q, pend_d;
  logic [CNT_W-1:0]          per_pend_q, per_pend_d;
  logic [NUM_CH*CNT_W-1:0]   duty_pend_q, duty_pend_d;
  logic [CNT_W-1:0]          per_act_q, per_act_d;
  logic [NUM_CH*CNT_W-1:0]   duty_act_q, duty_act_d;
  logic [WD_W-1:0]           wdog_q, wdog_d;
  logic                      fs_q, fs_d;
  logic [NUM_CH-1:0]         pwm_q, pwm_d;
  logic                      ps_q, ps_d;
  logic                      step, accept, wrap, apply;
  // Sequencing, counter, shadow-register load and watchdog; a boundary sees the pend value from before this edge
  always_comb begin
    step        = tick_i & ~tick_q;
    accept      = upd_valid_i & ~pend_q;
    wrap        = (per_act_q == '0) || (cnt_q == per_act_q - CNT_W'(1));
    apply       = 1'b0;
    ps_d        = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    per_pend_d  = per_pend_q;
    duty_pend_d = duty_pend_q;
    per_act_d   = per_act_q;
    duty_act_d  = duty_act_q;
    wdog_d      = wdog_q;
    fs_d        = fs_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
      if (enable_i) begin
        state_d = RUN;
        apply   = 1'b1;
      end
    end else if (!enable_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      wdog_d  = '0;
    end else if (step) begin
      apply = wrap;
      ps_d  = wrap;
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    end
    if (apply && pend_q) begin
      per_act_d  = per_pend_q;
      duty_act_d = duty_pend_q;
      pend_d     = 1'b0;
      wdog_d     = '0;
      fs_d       = 1'b0;
    end else if (apply && (WDOG_PERIODS != 0) && (wdog_q < WD_MAX)) begin
      wdog_d = wdog_q + WD_W'(1);
      if (wdog_d == WD_MAX) begin
        fs_d       = 1'b1;
        duty_act_d = {NUM_CH{FS_DUTY}};
      end
    end
    if (accept) begin
      pend_d      = 1'b1;
      per_pend_d  = period_i;
      duty_pend_d = duty_i;
    end
  end
  // Per-channel compare against the current count; registered so pwm_o lags cnt by one clock
  always_comb begin
    pwm_d = '0;
    for (int c = 0; c < NUM_CH; c++)
      pwm_d[c] = (state_q == RUN) && (per_act_q != '0) && (cnt_q < duty_act_q[c*CNT_W +: CNT_W]);
  end
  // State register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      tick_q      <= 1'b0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      per_pend_q  <= '0;
      duty_pend_q <= '0;
      per_act_q   <= '0;
      duty_act_q  <= '0;
      wdog_q      <= '0;
      fs_q        <= 1'b0;
      pwm_q       <= '0;
      ps_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_i;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      per_pend_q  <= per_pend_d;
      duty_pend_q <= duty_pend_d;
      per_act_q   <= per_act_d;
      duty_act_q  <= duty_act_d;
      wdog_q      <= wdog_d;
      fs_q        <= fs_d;
      pwm_q       <= pwm_d;
      ps_q        <= ps_d;
    end
  end
  assign upd_ready_o    = ~pend_q;
  assign pwm_o          = pwm_q;
  assign period_start_o = ps_q;
  assign failsafe_o     = fs_q;
endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: directed stimulus with a behavioural scoreboard for pwm_gen
module tb_pwm_gen;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  localparam int WD     = 4;
  localparam int FSD    = 2;
  typedef struct packed {
    logic [NUM_CH-1:0] pwm;
    logic              ps;
    logic              fs;
    logic              rdy;
  } exp_t;
  logic                    clk = 1'b0;
  logic                    rst_i = 1'b1;
  logic                    tick_i = 1'b0;
  logic                    enable_i = 1'b0;
  logic                    upd_valid_i = 1'b0;
  logic                    upd_ready_o;
  logic [CNT_W-1:0]        period_i = '0;
  logic [NUM_CH*CNT_W-1:0] duty_i = '0;
  logic [NUM_CH-1:0]       pwm_o;
  logic                    period_start_o;
  logic                    failsafe_o;
  int checks = 0;
  int fails = 0;
  exp_t sb_q[$];
  bit m_run, m_tq, m_pend, m_fs;
  int m_cnt, m_per, m_pper, m_wd;
  int m_duty[NUM_CH];
  int m_pduty[NUM_CH];
  always #5 clk = ~clk;
  pwm_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .WDOG_PERIODS(WD), .FAILSAFE_DUTY(FSD)) dut (
    .clk_i(clk), .rst_i(rst_i), .tick_i(tick_i), .enable_i(enable_i),
    .upd_valid_i(upd_valid_i), .upd_ready_o(upd_ready_o), .period_i(period_i),
    .duty_i(duty_i), .pwm_o(pwm_o), .period_start_o(period_start_o), .failsafe_o(failsafe_o)
  );
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // One clock: advance the behavioural model for this edge, push expectations, then compare after the edge
  task automatic cyc();
    exp_t e, o;
    bit step, acc, ap;
    e = '0;
    if (rst_i) begin
      m_run = 0; m_pend = 0; m_fs = 0; m_cnt = 0; m_per = 0; m_wd = 0;
      for (int c = 0; c < NUM_CH; c++) m_duty[c] = 0;
      e.rdy = 1'b1;
    end else begin
      for (int c = 0; c < NUM_CH; c++) e.pwm[c] = m_run && (m_per != 0) && (m_cnt < m_duty[c]);
      step = tick_i && !m_tq;
      acc  = upd_valid_i && !m_pend;
      ap   = 0;
      if (!m_run) begin
        m_cnt = 0;
        if (enable_i) begin m_run = 1; ap = 1; end
      end else if (!enable_i) begin
        m_run = 0; m_cnt = 0; m_wd = 0;
      end else if (step) begin
        if (m_per == 0 || m_cnt == m_per - 1) begin m_cnt = 0; ap = 1; e.ps = 1'b1; end
        else m_cnt++;
      end
      if (ap) begin
        if (m_pend) begin
          m_per = m_pper; m_pend = 0; m_wd = 0; m_fs = 0;
          for (int c = 0; c < NUM_CH; c++) m_duty[c] = m_pduty[c];
        end else if (m_wd < WD) begin
          m_wd++;
          if (m_wd == WD) begin
            m_fs = 1;
            for (int c = 0; c < NUM_CH; c++) m_duty[c] = FSD;
          end
        end
      end
      if (acc) begin
        m_pend = 1; m_pper = period_i;
        for (int c = 0; c < NUM_CH; c++) m_pduty[c] = duty_i[c*CNT_W +: CNT_W];
      end
      e.fs  = m_fs;
      e.rdy = !m_pend;
    end
    m_tq = rst_i ? 1'b0 : tick_i;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    o = sb_q.pop_front();
    chk("pwm_o", 32'(pwm_o), 32'(o.pwm));
    chk("period_start_o", 32'(period_start_o), 32'(o.ps));
    chk("failsafe_o", 32'(failsafe_o), 32'(o.fs));
    chk("upd_ready_o", 32'(upd_ready_o), 32'(o.rdy));
  endtask
  task automatic steps(int n);
    repeat (n) begin
      tick_i = 1'b1; cyc();
      tick_i = 1'b0; cyc();
    end
  endtask
  task automatic set_upd(int per, int d0, int d1, int d2, int d3);
    period_i = CNT_W'(per);
    duty_i   = {CNT_W'(d3), CNT_W'(d2), CNT_W'(d1), CNT_W'(d0)};
  endtask
  task automatic upd(int per, int d0, int d1, int d2, int d3);
    set_upd(per, d0, d1, d2, d3);
    upd_valid_i = 1'b1; cyc();
    upd_valid_i = 1'b0;
  endtask
  initial begin
    #1;
    rst_i = 1'b1; cyc(); cyc();
    rst_i = 1'b0; cyc();
    // basic duty patterns, including zero and over-period duty
    upd(10, 3, 0, 10, 12);
    enable_i = 1'b1; cyc();
    steps(20);
    // mid-period update applies only at the next boundary; second valid waits on ready
    steps(4);
    upd(10, 7, 0, 10, 12);
    set_upd(10, 5, 1, 9, 0);
    upd_valid_i = 1'b1;
    steps(6);
    upd_valid_i = 1'b0;
    steps(10);
    // tick held high counts a single step
    tick_i = 1'b1;
    repeat (20) cyc();
    tick_i = 1'b0; cyc();
    steps(9);
    // watchdog trips with no updates, then a loaded update clears it
    steps(50);
    chk("wdog_trip", 32'(failsafe_o), 32'd1);
    upd(10, 1, 2, 3, 4);
    steps(10);
    chk("wdog_clear", 32'(failsafe_o), 32'd0);
    // disable mid-period, re-enable with a pending update
    for (int i = 0; i < 12 && m_cnt != 5; i++) steps(1);
    enable_i = 1'b0; cyc(); cyc();
    chk("pwm_idle", 32'(pwm_o), 32'd0);
    upd(20, 4, 8, 20, 25);
    cyc();
    enable_i = 1'b1; cyc();
    steps(22);
    // reset mid-period with an update pending and activity on the inputs
    steps(3);
    upd(10, 6, 6, 6, 6);
    steps(2);
    tick_i = 1'b1; upd_valid_i = 1'b1; rst_i = 1'b1;
    cyc();
    rst_i = 1'b0; tick_i = 1'b0; upd_valid_i = 1'b0; enable_i = 1'b0;
    chk("ready_after_rst", 32'(upd_ready_o), 32'd1);
    cyc(); cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
